// File: rtl/minirisc_acc_core.sv
// minirisc_acc_core: accumulator-style mini-RISC core with a writable program memory.
// Execution takes two cycles per instruction (FETCH then EXEC). OUT additionally waits
// in OUTW until the consumer takes the value.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-high reset
//   ena                  0 freezes every register, including program-memory writes
//   prog_we/addr/data    program-memory write port, honoured only in IDLE or HALT
//   start                pulse in IDLE or HALT to run from PC=0
//   out_data/valid/ready ready/valid result port driven by the OUT instruction
//   acc_out, pc_out      architectural accumulator and program counter
//   state_out            0 IDLE, 1 FETCH, 2 EXEC, 3 OUTW, 4 HALT
//   zero, carry, halted  flags and the HALT state indicator
module minirisc_acc_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned IMEM_DEPTH = 16,
  localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [2:0]        state_out,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_OUTW  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LDR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [2:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [15:0]       ir_q, ir_d;

  logic              idle_like;
  logic [3:0]        op;
  logic [RW-1:0]     reg_idx;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rdata;
  logic [PC_W-1:0]   jmp_tgt;
  logic [PC_W-1:0]   pc_inc;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              acc_wr;
  logic              reg_we;
  logic              unused_ir;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);
  assign op        = ir_q[15:12];
  assign reg_idx   = ir_q[8 +: RW];
  assign imm_ext   = DATA_W'(ir_q[7:0]);
  assign jmp_tgt   = PC_W'(ir_q[7:0]);
  assign rdata     = regs_q[reg_idx];
  assign pc_inc    = pc_q + PC_W'(1);
  // Extra top bit carries out of ADD; for SUB it is set exactly when a borrow occurs.
  assign sum       = {1'b0, acc_q} + {1'b0, rdata};
  assign diff      = {1'b0, acc_q} - {1'b0, rdata};
  // Register-index and immediate bits beyond the configured widths are ignored.
  assign unused_ir = ^ir_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ir_d        = ir_q;
    acc_wr      = 1'b0;
    reg_we      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          zero_d  = 1'b0;
          carry_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_LDI: begin acc_d = imm_ext;       acc_wr = 1'b1; end
          OP_ADD: begin acc_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];  acc_wr = 1'b1; end
          OP_SUB: begin acc_d = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; acc_wr = 1'b1; end
          OP_AND: begin acc_d = acc_q & rdata; acc_wr = 1'b1; end
          OP_OR:  begin acc_d = acc_q | rdata; acc_wr = 1'b1; end
          OP_XOR: begin acc_d = acc_q ^ rdata; acc_wr = 1'b1; end
          OP_MOV: reg_we = 1'b1;
          OP_LDR: begin acc_d = rdata;         acc_wr = 1'b1; end
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (zero_q)  pc_d = jmp_tgt;
          OP_JC:  if (carry_q) pc_d = jmp_tgt;
          OP_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q;
            state_d     = ST_OUTW;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
        if (acc_wr) zero_d = (acc_d == '0);
      end
      ST_OUTW: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ir_q        <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ir_q        <= ir_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (ena && reg_we) begin
      regs_q[reg_idx] <= acc_q;
    end
  end

  // Program memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (ena && prog_we && idle_like) imem[prog_addr] <= prog_data;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign state_out = state_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_minirisc_acc_core.sv
module tb_minirisc_acc_core;

  logic       clk = 1'b0;
  logic       rst, ena, prog_we, start, out_ready;
  logic [3:0] prog_addr;
  logic [15:0] prog_data;
  logic [7:0] out_data, acc_out;
  logic       out_valid, zero, carry, halted;
  logic [3:0] pc_out;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prog [16];

  always #5 clk = ~clk;

  minirisc_acc_core #(
    .DATA_W(8),
    .NREGS(4),
    .IMEM_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start(start),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out),
    .pc_out(pc_out),
    .state_out(state_out),
    .zero(zero),
    .carry(carry),
    .halted(halted)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r,
                                      input logic [7:0] imm);
    return {op, r, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
      tick(1);
    end
    prog_we = 1'b0;
  endtask

  // Runs until HALT, counting sampled out_valid cycles and noting whether pc reached 15.
  task automatic wait_halt(input string tag, output int outs, output logic [7:0] last,
                           output logic saw_top);
    int cyc;
    outs = 0; last = 8'h00; saw_top = 1'b0; cyc = 0;
    while (!halted && cyc < 200) begin
      if (out_valid) begin outs++; last = out_data; end
      if (pc_out == 4'd15) saw_top = 1'b1;
      tick(1);
      cyc++;
    end
    check({tag, "_halt_in_budget"}, 32'(halted), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_prog1();
    clear_prog();
    prog[0] = ins(4'h1, 4'h0, 8'h05);
    prog[1] = ins(4'h7, 4'h1, 8'h00);
    prog[2] = ins(4'h1, 4'h0, 8'h03);
    prog[3] = ins(4'h2, 4'h1, 8'h00);
    prog[4] = ins(4'hC, 4'h0, 8'h00);
    prog[5] = ins(4'hF, 4'h0, 8'h00);
    load_prog();
  endtask

  int         outs;
  logic [7:0] last;
  logic       saw_top;
  int         cyc;

  initial begin
    rst = 1'b1; ena = 1'b1; prog_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    prog_addr = '0; prog_data = '0;
    tick(2);
    check("rst_state", 32'(state_out), 0);
    check("rst_pc", 32'(pc_out), 0);
    check("rst_acc", 32'(acc_out), 0);
    check("rst_flags", 32'({out_valid, zero, carry, halted}), 0);
    rst = 1'b0;
    tick(1);

    // Basic add-and-output program.
    load_prog1();
    pulse_start();
    wait_halt("p1", outs, last, saw_top);
    check("p1_outs", 32'(outs), 1);
    check("p1_out_data", 32'(last), 32'h08);
    check("p1_pc", 32'(pc_out), 5);
    check("p1_acc", 32'(acc_out), 32'h08);
    check("p1_state", 32'(state_out), 4);
    check("p1_zc", 32'({zero, carry}), 0);

    // ADD overflow sets carry and zero; JC taken.
    clear_prog();
    prog[0] = ins(4'h1, 4'h0, 8'hFF);
    prog[1] = ins(4'h7, 4'h0, 8'h00);
    prog[2] = ins(4'h1, 4'h0, 8'h01);
    prog[3] = ins(4'h2, 4'h0, 8'h00);
    prog[4] = ins(4'hB, 4'h0, 8'h06);
    load_prog();
    pulse_start();
    wait_halt("jc", outs, last, saw_top);
    check("jc_pc", 32'(pc_out), 6);
    check("jc_acc", 32'(acc_out), 0);
    check("jc_zero", 32'(zero), 1);
    check("jc_carry", 32'(carry), 1);

    // SUB borrow, JZ not taken, XOR keeps carry.
    clear_prog();
    prog[0] = ins(4'h1, 4'h0, 8'h02);
    prog[1] = ins(4'h7, 4'h2, 8'h00);
    prog[2] = ins(4'h1, 4'h0, 8'h01);
    prog[3] = ins(4'h3, 4'h2, 8'h00);
    prog[4] = ins(4'hA, 4'h0, 8'h07);
    prog[5] = ins(4'h6, 4'h2, 8'h00);
    load_prog();
    pulse_start();
    wait_halt("sub", outs, last, saw_top);
    check("sub_pc", 32'(pc_out), 6);
    check("sub_acc", 32'(acc_out), 32'hFD);
    check("sub_carry", 32'(carry), 1);
    check("sub_zero", 32'(zero), 0);

    // OUT back-pressure, then ena=0 freezes OUTW even with ready high.
    clear_prog();
    prog[0] = ins(4'h1, 4'h0, 8'h5A);
    prog[1] = ins(4'hC, 4'h0, 8'h00);
    load_prog();
    out_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(1); cyc++; end
    check("bp_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h5A);
      check("bp_pc", 32'(pc_out), 1);
      tick(1);
    end
    ena = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check("frz_valid", 32'(out_valid), 1);
    check("frz_state", 32'(state_out), 3);
    ena = 1'b1;
    tick(1);
    check("bp_done_valid", 32'(out_valid), 0);
    check("bp_done_state", 32'(state_out), 1);
    check("bp_done_pc", 32'(pc_out), 2);
    wait_halt("bp", outs, last, saw_top);
    check("bp_no_extra_out", 32'(outs), 0);
    check("bp_final_pc", 32'(pc_out), 2);

    // PC wrap: JMP 15, NOP at 15 wraps to 0, JZ then lands on HALT at 3.
    clear_prog();
    prog[0]  = ins(4'hA, 4'h0, 8'h03);
    prog[1]  = ins(4'h1, 4'h0, 8'h00);
    prog[2]  = ins(4'h9, 4'h0, 8'h0F);
    prog[15] = ins(4'h0, 4'h0, 8'h00);
    load_prog();
    pulse_start();
    wait_halt("wrap", outs, last, saw_top);
    check("wrap_saw_pc15", 32'(saw_top), 1);
    check("wrap_pc", 32'(pc_out), 3);

    // Asynchronous reset during EXEC of ADD, then an identical re-run.
    load_prog1();
    pulse_start();
    cyc = 0;
    while (!(state_out == 3'd2 && pc_out == 4'd3) && cyc < 20) begin tick(1); cyc++; end
    check("rst_mid_reached", 32'(state_out), 2);
    rst = 1'b1;
    #1;
    check("rst_mid_state", 32'(state_out), 0);
    check("rst_mid_pc", 32'(pc_out), 0);
    check("rst_mid_acc", 32'(acc_out), 0);
    tick(1);
    rst = 1'b0;
    pulse_start();
    wait_halt("rerun", outs, last, saw_top);
    check("rerun_outs", 32'(outs), 1);
    check("rerun_out_data", 32'(last), 32'h08);
    check("rerun_pc", 32'(pc_out), 5);

    // prog_we while running is ignored; ena=0 freezes mid-run.
    pulse_start();
    tick(2);
    prog_we = 1'b1; prog_addr = 4'd4; prog_data = 16'hF000;
    tick(1);
    prog_we = 1'b0;
    check("run_state", 32'(state_out), 2);
    ena = 1'b0;
    tick(3);
    check("ena0_state", 32'(state_out), 2);
    check("ena0_pc", 32'(pc_out), 1);
    check("ena0_acc", 32'(acc_out), 5);
    ena = 1'b1;
    wait_halt("ena", outs, last, saw_top);
    check("ena_outs", 32'(outs), 1);
    pulse_start();
    wait_halt("we", outs, last, saw_top);
    check("we_ignored_outs", 32'(outs), 1);
    check("we_ignored_data", 32'(last), 32'h08);
    check("we_ignored_pc", 32'(pc_out), 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
